exec_stub: RTL and testbench
============================

EXEC_STUB -- requirements
Module: exec_stub

Interface
REQ-001 Parameter ADDR_WIDTH, 12, width of PC_value and base_addr; SHALL apply to all PC arithmetic.
REQ-002 Parameter START_PC, 12'o200, PC_value after reset.
REQ-003 Parameter CNT_WIDTH, 16, width of instr_count.
REQ-004 Parameter NUM_INSTR, 1000, number of main-phase instructions executed before the jump back to base_addr.
REQ-005 Parameter TAIL_INSTR, 5, number of instructions executed after the jump.
REQ-006 Parameter MIN_DELAY, 2, minimum execute cycles per instruction, 1..15.
REQ-007 Parameter MEM_EXTRA, 1, extra execute cycles for memory-class instructions.
REQ-008 Parameter LFSR_SEED, 16'hACE1, LFSR reset value, nonzero.
REQ-009 Port clk, in, 1, free-running clock; all state SHALL update on its rising edge.
REQ-010 Port reset, in, 1, synchronous, active-high reset.
REQ-011 Port enable, in, 1, allows the stub to accept instructions.
REQ-012 Port mode, in, 1, 0 = fixed delay, 1 = LFSR random delay.
REQ-013 Port fixed_delay, in, 4, execute cycles in fixed mode; a value below MIN_DELAY SHALL be treated as MIN_DELAY.
REQ-014 Port base_addr, in, ADDR_WIDTH, first-instruction address from instr_decode.
REQ-015 Port instr_valid, in, 1, decoder presents a decoded instruction this cycle.
REQ-016 Port pdp_mem_opcode, in, pdp_mem_opcode_s, decoded memory instruction; any field set marks the instruction as memory-class.
REQ-017 Port pdp_op7_opcode, in, pdp_op7_opcode_s, decoded op7 instruction; accepted, and class-neutral.
REQ-018 Port stall, out, 1, stalls instr_decode.
REQ-019 Port PC_value, out, ADDR_WIDTH, current program counter.
REQ-020 Port instr_count, out, CNT_WIDTH, instructions retired since reset.
REQ-021 Port done, out, 1, sticky end-of-test flag.

Function
REQ-022 The FSM SHALL have the states IDLE, RUN, EXEC and DONE, plus a phase bit (MAIN/TAIL).
REQ-023 In IDLE, stall SHALL be 1; when enable=1 the FSM SHALL move to RUN on the next edge.
REQ-024 In RUN, stall SHALL be 0; instr_valid=1 SHALL latch the delay D, set stall=1 on the next edge and enter EXEC.
REQ-025 Delay D SHALL be max(MIN_DELAY, fixed_delay) in fixed mode and MIN_DELAY + (lfsr[3:0] % 15) in random mode, plus MEM_EXTRA for memory-class instructions.
REQ-026 EXEC SHALL hold stall=1 for exactly D cycles; on the last EXEC cycle it SHALL update PC_value, increment instr_count and return to RUN, or go to IDLE if enable=0.
REQ-027 In the MAIN phase, PC_value SHALL increment by 1 modulo 2^ADDR_WIDTH, so 12'o7777 wraps to 0.
REQ-028 When instr_count reaches NUM_INSTR, the PC update SHALL load base_addr instead of incrementing, and the phase SHALL switch to TAIL.
REQ-029 When TAIL_INSTR instructions have retired in the TAIL phase, the FSM SHALL enter DONE: stall=1, done=1, both held until reset.
REQ-030 instr_valid SHALL be ignored while stall=1 or in IDLE/DONE.
REQ-031 enable=0 in RUN SHALL go to IDLE on the next edge; in EXEC the current instruction SHALL complete first.
REQ-032 instr_count SHALL saturate at its all-ones value.
REQ-033 The LFSR SHALL be a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances every non-reset cycle.

Reset
REQ-034 reset=1 at any edge, including mid-EXEC or in DONE, SHALL give state=IDLE, phase=MAIN, stall=1, PC_value=START_PC, instr_count=0, done=0, lfsr=LFSR_SEED.
REQ-035 reset SHALL take priority over every other input.

Structure
REQ-036 exec_stub_state_e and exec_mode_e SHALL be defined in pdp8_pkg; ADDR_WIDTH defaults SHALL come from the same package.
REQ-037 The LFSR SHALL be a separate sub-module, exec_lfsr, with its seed as a parameter; all other logic SHALL stay in exec_stub.

Verification
REQ-038 Reset, then enable=1, mode=0, fixed_delay=3, instr_valid pulsed -> stall 0 in RUN, then 1 for 3 cycles, PC 12'o200 -> 12'o201, instr_count=1.
REQ-039 Memory-class instruction, fixed_delay=2, MEM_EXTRA=1 -> stall held for 3 cycles.
REQ-040 START_PC=12'o7777, one instruction retired -> PC_value=0.
REQ-041 NUM_INSTR=4, TAIL_INSTR=2, base_addr=12'h80 -> after the 4th retire PC=12'h80; after 2 more, done=1, stall=1, both stuck.
REQ-042 Reset asserted on the 2nd EXEC cycle -> next edge stall=1, PC=START_PC, instr_count=0, and no PC update.
REQ-043 mode=1, 200 instructions -> every stall-high run is within [MIN_DELAY, MIN_DELAY+14+MEM_EXTRA], and the delay sequence is repeatable for the same seed.

Source files
------------

// File: rtl/pdp8_pkg.sv
// pdp8_pkg
// Shared types and defaults for the PDP-8 execution stub.
// Contents:
//   - PDP8_ADDR_WIDTH / PDP8_START_PC : default address width and reset PC.
//   - exec_stub_state_e : execution stub FSM states.
//   - exec_mode_e       : delay source (fixed input value or LFSR).
//   - exec_phase_e      : MAIN phase (counting up) or TAIL phase (after the jump).
//   - pdp_mem_opcode_s  : one-hot flags of a decoded memory-reference instruction.
//   - pdp_op7_opcode_s  : flags of a decoded operate (opcode 7) instruction.
//   - lfsrNext()        : one step of the 16-bit Galois LFSR x^16+x^14+x^13+x^11+1.
package pdp8_pkg;

    localparam int              PDP8_ADDR_WIDTH = 12;
    localparam logic [11:0]     PDP8_START_PC   = 12'o200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } exec_stub_state_e;

    typedef enum logic {
        MODE_FIXED  = 1'b0,
        MODE_RANDOM = 1'b1
    } exec_mode_e;

    typedef enum logic {
        PHASE_MAIN = 1'b0,
        PHASE_TAIL = 1'b1
    } exec_phase_e;

    typedef struct packed {
        logic AND;
        logic TAD;
        logic ISZ;
        logic DCA;
        logic JMS;
        logic JMP;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLA;
        logic CLL;
        logic HLT;
    } pdp_op7_opcode_s;

    // Right-shifting Galois form: the bit shifted out is folded back into the
    // tap positions 16, 14, 13 and 11, which gives the constant 16'hB400.
    function automatic logic [15:0] lfsrNext(input logic [15:0] value);
        logic [15:0] shifted;
        shifted = value >> 1;
        if (value[0]) begin
            shifted = shifted ^ 16'hB400;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/exec_lfsr.sv
// exec_lfsr
// Free-running 16-bit Galois LFSR used as the random delay source of exec_stub.
// Ports:
//   i_clk   - clock, state advances on every rising edge
//   i_reset - synchronous active-high reset, loads SEED
//   o_lfsr  - current LFSR value
// SEED must be nonzero, otherwise the register locks up at zero.
module exec_lfsr
    import pdp8_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    // Advance once per cycle regardless of what the stub is doing, so the
    // delay sequence depends only on the cycle distance from reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsrNext(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/exec_stub.sv
// exec_stub
// Stand-in for the PDP-8 execute stage. It accepts decoded instructions from
// instr_decode, holds the decoder off with stall for a programmable number of
// cycles per instruction, then retires it by advancing PC_value and
// instr_count. After NUM_INSTR retires the PC is reloaded from base_addr and
// TAIL_INSTR more instructions are run before the stub parks in DONE.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   enable           - allows instructions to be accepted
//   mode             - 0: fixed delay from fixed_delay, 1: LFSR random delay
//   fixed_delay      - execute cycles in fixed mode (clamped up to MIN_DELAY)
//   base_addr        - PC loaded at the MAIN -> TAIL jump
//   instr_valid      - decoder presents an instruction this cycle
//   pdp_mem_opcode   - memory-reference flags; any set flag adds MEM_EXTRA cycles
//   pdp_op7_opcode   - operate flags; accepted but do not change timing
//   stall            - holds instr_decode off
//   PC_value         - current program counter
//   instr_count      - saturating count of retired instructions
//   done             - sticky end-of-test flag
module exec_stub
    import pdp8_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PDP8_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_PC   = ADDR_WIDTH'(PDP8_START_PC),
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    NUM_INSTR  = 1000,
    parameter int                    TAIL_INSTR = 5,
    parameter int                    MIN_DELAY  = 2,
    parameter int                    MEM_EXTRA  = 1,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [3:0]            fixed_delay,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  instr_valid,
    input  pdp_mem_opcode_s       pdp_mem_opcode,
    input  pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] PC_value,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic                  done
);

    localparam logic [7:0]            MIN_D   = 8'(MIN_DELAY);
    localparam logic [7:0]            EXTRA_D = 8'(MEM_EXTRA);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  NUM_C   = CNT_WIDTH'(NUM_INSTR);
    localparam logic [CNT_WIDTH-1:0]  TAIL_C  = CNT_WIDTH'(TAIL_INSTR);

    exec_stub_state_e      r_state;
    exec_phase_e           r_phase;
    logic                  r_stall;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_tailCount;
    logic [7:0]            r_remain;

    logic [15:0]           w_lfsr;
    exec_mode_e            w_mode;
    logic                  w_isMem;
    logic [3:0]            w_rand;
    logic [7:0]            w_baseDelay;
    logic [7:0]            w_delay;
    logic [CNT_WIDTH-1:0]  w_countNext;
    logic [CNT_WIDTH-1:0]  w_tailNext;
    logic                  w_unusedBits;

    exec_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk),
        .i_reset (reset),
        .o_lfsr  (w_lfsr)
    );

    assign w_mode       = exec_mode_e'(mode);
    assign w_isMem      = |pdp_mem_opcode;
    assign w_countNext  = (&r_count) ? r_count : r_count + CNT_ONE;
    assign w_tailNext   = r_tailCount + CNT_ONE;
    // Operate flags never affect timing and only the low LFSR nibble feeds
    // the delay; fold the rest into one sink so the intent is explicit.
    assign w_unusedBits = ^{pdp_op7_opcode, w_lfsr[15:4]};

    // Delay for the instruction being accepted this cycle. The random term
    // uses lfsr[3:0] mod 15 so the range is 0..14 and 15 aliases onto 0.
    always_comb begin
        w_rand = w_lfsr[3:0] % 4'd15;
        if (w_mode == MODE_RANDOM) begin
            w_baseDelay = MIN_D + {4'b0000, w_rand};
        end else if ({4'b0000, fixed_delay} < MIN_D) begin
            w_baseDelay = MIN_D;
        end else begin
            w_baseDelay = {4'b0000, fixed_delay};
        end
        w_delay = w_baseDelay + (w_isMem ? EXTRA_D : 8'd0);
    end

    // Control FSM. stall and done are registered alongside the state so they
    // change on the same edge as the state they belong to. r_remain counts
    // the EXEC cycles left including the current one; the retire happens on
    // the edge that ends the cycle where it reads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= PHASE_MAIN;
            r_stall     <= 1'b1;
            r_done      <= 1'b0;
            r_pc        <= START_PC;
            r_count     <= '0;
            r_tailCount <= '0;
            r_remain    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= RUN;
                        r_stall <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_stall <= 1'b1;
                    end else if (instr_valid) begin
                        r_remain <= w_delay;
                        r_state  <= EXEC;
                        r_stall  <= 1'b1;
                    end
                end
                EXEC: begin
                    if (r_remain > 8'd1) begin
                        r_remain <= r_remain - 8'd1;
                    end else begin
                        r_count <= w_countNext;
                        if (r_phase == PHASE_MAIN && w_countNext == NUM_C) begin
                            r_pc    <= base_addr;
                            r_phase <= PHASE_TAIL;
                        end else begin
                            r_pc <= r_pc + PC_ONE;
                        end
                        if (r_phase == PHASE_TAIL) begin
                            r_tailCount <= w_tailNext;
                        end
                        if (r_phase == PHASE_TAIL && w_tailNext == TAIL_C) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (enable) begin
                            r_state <= RUN;
                            r_stall <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    r_stall <= 1'b1;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_stall <= 1'b1;
                end
            endcase
        end
    end

    assign stall       = r_stall;
    assign done        = r_done;
    assign PC_value    = r_pc;
    assign instr_count = r_count;

endmodule

// File: tb/tb_exec_stub.sv
// tb_exec_stub
// Directed bench for exec_stub. dutA uses the default parameters; dutB starts
// at 12'o7777 with NUM_INSTR=4 and TAIL_INSTR=2 for the wrap, jump and DONE
// behaviour. Both see the same stimulus; 'sel' picks which one the monitor
// scores. Each issued instruction pushes its expected delay, PC and count into
// a queue that the monitor pops whenever instr_count changes.
module tb_exec_stub;
    import pdp8_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            mode;
    logic            instrValid;
    logic [3:0]      fixedDelay;
    logic [11:0]     baseAddr;
    pdp_mem_opcode_s memOp;
    pdp_op7_opcode_s op7Op;

    logic            stallA, stallB, doneA, doneB;
    logic [11:0]     pcA, pcB;
    logic [15:0]     countA, countB;

    bit              sel;
    logic            monStall;
    logic [11:0]     monPc;
    logic [15:0]     monCount;

    int              errors = 0;
    int              checks = 0;

    typedef struct {
        int          delay;
        logic [11:0] pc;
        logic [15:0] count;
        bit          randomMode;
    } exp_t;

    exp_t            expQ[$];
    logic [15:0]     modelLfsr;
    logic [11:0]     modelPc;
    logic [15:0]     modelCount;
    int              modelNum;

    always #5 clk = ~clk;

    exec_stub dutA (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .fixed_delay    (fixedDelay),
        .base_addr      (baseAddr),
        .instr_valid    (instrValid),
        .pdp_mem_opcode (memOp),
        .pdp_op7_opcode (op7Op),
        .stall          (stallA),
        .PC_value       (pcA),
        .instr_count    (countA),
        .done           (doneA)
    );

    exec_stub #(
        .START_PC   (12'o7777),
        .NUM_INSTR  (4),
        .TAIL_INSTR (2)
    ) dutB (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .fixed_delay    (fixedDelay),
        .base_addr      (baseAddr),
        .instr_valid    (instrValid),
        .pdp_mem_opcode (memOp),
        .pdp_op7_opcode (op7Op),
        .stall          (stallB),
        .PC_value       (pcB),
        .instr_count    (countB),
        .done           (doneB)
    );

    assign monStall = sel ? stallB : stallA;
    assign monPc    = sel ? pcB    : pcA;
    assign monCount = sel ? countB : countA;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, reset to the default seed.
    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) modelLfsr <= 16'hACE1;
        else       modelLfsr <= lfsrStep(modelLfsr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset(input bit which);
        @(negedge clk);
        reset      = 1'b1;
        enable     = 1'b0;
        instrValid = 1'b0;
        @(negedge clk);
        sel        = which;
        expQ.delete();
        modelPc    = which ? 12'o7777 : 12'o200;
        modelCount = 16'd0;
        modelNum   = which ? 4 : 1000;
        @(negedge clk);
        reset      = 1'b0;
    endtask

    // Wait for RUN, present one instruction and queue what its retire must
    // look like. holdCycles keeps instr_valid high into EXEC, where it must
    // be ignored.
    task automatic applyStimulus(input bit isMem, input logic [3:0] delayIn,
                                 input int holdCycles);
        int   waited = 0;
        int   d;
        exp_t e;
        fixedDelay = delayIn;
        while (monStall !== 1'b0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (monStall !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall release timeout: stall=%b, expected 0", monStall);
            return;
        end
        memOp     = '0;
        memOp.TAD = isMem;
        op7Op     = '0;
        op7Op.IAC = !isMem;
        if (mode) d = 2 + int'(modelLfsr[3:0] % 4'd15);
        else      d = (delayIn < 4'd2) ? 2 : int'(delayIn);
        if (isMem) d = d + 1;
        modelCount = modelCount + 16'd1;
        modelPc    = (int'(modelCount) == modelNum) ? baseAddr : modelPc + 12'd1;
        e.delay      = d;
        e.pc         = modelPc;
        e.count      = modelCount;
        e.randomMode = mode;
        expQ.push_back(e);
        instrValid = 1'b1;
        @(negedge clk);
        repeat (holdCycles) @(negedge clk);
        instrValid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (expQ.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard drained", expQ.size(), 0);
    endtask

    // Monitor: counts consecutive stall-high samples; on every instr_count
    // change it scores the oldest queued expectation.
    initial begin
        int          highRun;
        logic [15:0] prevCount;
        exp_t        e;
        highRun   = 0;
        prevCount = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                highRun   = 0;
                prevCount = '0;
            end else begin
                if (monCount !== prevCount) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected retire: instr_count=%0d, expected none", monCount);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("exec stall cycles", highRun, e.delay);
                        checkOutput("PC after retire", monPc, e.pc);
                        checkOutput("instr_count after retire", monCount, e.count);
                        if (e.randomMode)
                            checkOutput("random delay in range", (highRun >= 2 && highRun <= 17), 1);
                    end
                end
                if (monStall) highRun++;
                else          highRun = 0;
                prevCount = monCount;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        mode       = 1'b0;
        instrValid = 1'b0;
        fixedDelay = 4'd0;
        baseAddr   = 12'h80;
        memOp      = '0;
        op7Op      = '0;
        sel        = 1'b0;
        modelNum   = 1000;

        applyReset(1'b0);
        checkOutput("reset stall", stallA, 1);
        checkOutput("reset PC", pcA, 12'o200);
        checkOutput("reset instr_count", countA, 0);
        checkOutput("reset done", doneA, 0);
        checkOutput("reset PC dutB", pcB, 12'o7777);

        enable = 1'b1;
        @(negedge clk);
        checkOutput("RUN stall", stallA, 0);

        applyStimulus(1'b0, 4'd3, 0);
        applyStimulus(1'b1, 4'd2, 0);
        applyStimulus(1'b0, 4'd0, 0);
        applyStimulus(1'b1, 4'd1, 0);
        applyStimulus(1'b0, 4'd15, 0);
        applyStimulus(1'b0, 4'd5, 3);
        waitDrain();

        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("IDLE stall after enable low", stallA, 1);
        instrValid = 1'b1;
        repeat (3) @(negedge clk);
        instrValid = 1'b0;
        checkOutput("count unchanged in IDLE", countA, modelCount);
        enable = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 4'd4, 0);
        enable = 1'b0;
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("stall held in IDLE after EXEC", stallA, 1);
        enable = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 4'd3, 0);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        expQ.delete();
        modelPc    = 12'o200;
        modelCount = 16'd0;
        checkOutput("stall after mid-EXEC reset", stallA, 1);
        checkOutput("PC after mid-EXEC reset", pcA, 12'o200);
        checkOutput("count after mid-EXEC reset", countA, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("no PC update after reset", pcA, 12'o200);
        checkOutput("no retire after reset", countA, 0);

        enable = 1'b1;
        mode   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(i % 3 == 0, 4'd0, 0);
        end
        waitDrain();
        mode = 1'b0;

        applyReset(1'b1);
        checkOutput("reset PC START_PC=7777", pcB, 12'o7777);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'd2, 0);
        end
        waitDrain();
        @(negedge clk);
        checkOutput("done after tail", doneB, 1);
        checkOutput("stall in DONE", stallB, 1);
        instrValid = 1'b1;
        repeat (10) @(negedge clk);
        instrValid = 1'b0;
        checkOutput("done sticky", doneB, 1);
        checkOutput("stall sticky", stallB, 1);
        checkOutput("PC frozen in DONE", pcB, 12'h82);
        checkOutput("count frozen in DONE", countB, 6);

        applyReset(1'b1);
        checkOutput("done cleared by reset", doneB, 0);
        checkOutput("PC restored by reset", pcB, 12'o7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
